// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS control unit: sequences each instruction through fetch/decode/
// execute/memory/writeback, stalls on mem_ready, resolves branches and counts retires.
module multi_cycle_ctrl #(
  parameter int OP_W    = 6,
  parameter int ALUOP_W = 2,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [OP_W-1:0]    op,
  input  logic               zero,
  input  logic               neg,
  input  logic               mem_ready,
  output logic               iord,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               pc_write,
  output logic               pc_src,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               alu_src,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               reg_write,
  output logic               illegal,
  output logic [3:0]         state,
  output logic [CNT_W-1:0]   instr_count
);

  localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_BNE   = OP_W'(6'b000101);
  localparam logic [OP_W-1:0] OP_BGTZ  = OP_W'(6'b000111);
  localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);
  localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'b001000);
  localparam logic [OP_W-1:0] OP_SLTI  = OP_W'(6'b001010);
  localparam logic [OP_W-1:0] OP_ANDI  = OP_W'(6'b001100);
  localparam logic [OP_W-1:0] OP_ORI   = OP_W'(6'b001101);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EX_R     = 4'd2,
    S_EX_I     = 4'd3,
    S_WB_R     = 4'd4,
    S_WB_I     = 4'd5,
    S_MEM_ADDR = 4'd6,
    S_MEM_RD   = 4'd7,
    S_WB_MEM   = 4'd8,
    S_MEM_WR   = 4'd9,
    S_BR       = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  state_t          state_q;
  state_t          state_next;
  logic [OP_W-1:0] op_q;
  logic            retire;
  logic            taken;

  assign state = state_q;

  // An instruction retires on the edge that leaves its last state; a store
  // only leaves MEM_WR once memory has accepted the write.
  assign retire = (state_q == S_WB_R) || (state_q == S_WB_I) ||
                  (state_q == S_WB_MEM) || (state_q == S_BR) ||
                  ((state_q == S_MEM_WR) && mem_ready);

  always_comb begin
    taken = 1'b0;
    case (op_q)
      OP_BEQ:  taken = zero;
      OP_BNE:  taken = !zero;
      OP_BGTZ: taken = !zero && !neg;
      default: taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_FETCH;
      op_q        <= '0;
      instr_count <= '0;
    end else begin
      state_q <= state_next;
      if (state_q == S_DECODE) begin
        op_q <= op;
      end
      if (retire) begin
        instr_count <= instr_count + CNT_W'(1);
      end
    end
  end

  // DECODE dispatches on the live opcode (op_q is being loaded on the same
  // edge); every later state only looks at op_q.
  always_comb begin
    state_next = state_q;
    case (state_q)
      S_FETCH:  if (mem_ready) state_next = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_RTYPE:                         state_next = S_EX_R;
          OP_BEQ, OP_BNE, OP_BGTZ:          state_next = S_BR;
          OP_LW, OP_SW:                     state_next = S_MEM_ADDR;
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: state_next = S_EX_I;
          default:                          state_next = S_TRAP;
        endcase
      end
      S_EX_R:     state_next = S_WB_R;
      S_EX_I:     state_next = S_WB_I;
      S_WB_R:     state_next = S_FETCH;
      S_WB_I:     state_next = S_FETCH;
      S_MEM_ADDR: state_next = (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   if (mem_ready) state_next = S_WB_MEM;
      S_WB_MEM:   state_next = S_FETCH;
      S_MEM_WR:   if (mem_ready) state_next = S_FETCH;
      S_BR:       state_next = S_FETCH;
      S_TRAP:     state_next = S_TRAP;
      default:    state_next = S_FETCH;
    endcase
  end

  // Outputs are forced low while rst is held so an aborted access never
  // reaches memory or the register bank.
  always_comb begin
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src    = 1'b0;
    alu_op     = '0;
    reg_write  = 1'b0;
    illegal    = 1'b0;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          mem_read = 1'b1;
          ir_write = mem_ready;
          pc_write = mem_ready;
        end
        S_EX_R: begin
          alu_op = ALUOP_W'(2'b10);
        end
        S_EX_I: begin
          alu_src = 1'b1;
          alu_op  = (op_q == OP_ADDI) ? ALUOP_W'(2'b00) : ALUOP_W'(2'b11);
        end
        S_WB_R: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
        end
        S_WB_I: begin
          reg_write = 1'b1;
        end
        S_MEM_ADDR: begin
          alu_src = 1'b1;
          alu_op  = ALUOP_W'(2'b00);
        end
        S_MEM_RD: begin
          mem_read = 1'b1;
          iord     = 1'b1;
        end
        S_WB_MEM: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        S_MEM_WR: begin
          mem_write = 1'b1;
          iord      = 1'b1;
        end
        S_BR: begin
          alu_op   = ALUOP_W'(2'b01);
          pc_src   = 1'b1;
          pc_write = taken;
        end
        S_TRAP: begin
          illegal = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed bench for multi_cycle_ctrl: an instruction-level model predicts every
// cycle's control outputs and the retire count, checked on each falling edge.
module tb_multi_cycle_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, zero, neg, mem_ready;
  logic [5:0] op;

  logic        iord, mem_read, mem_write, ir_write, pc_write, pc_src;
  logic        reg_dst, mem_to_reg, alu_src, reg_write, illegal;
  logic [1:0]  alu_op;
  logic [3:0]  state;
  logic [31:0] instr_count;

  logic        w_iord, w_mem_read, w_mem_write, w_ir_write, w_pc_write, w_pc_src;
  logic        w_reg_dst, w_mem_to_reg, w_alu_src, w_reg_write, w_illegal;
  logic [1:0]  w_alu_op;
  logic [3:0]  w_state;
  logic [1:0]  w_instr_count;

  multi_cycle_ctrl dut (
    .clk(clk), .rst(rst), .op(op), .zero(zero), .neg(neg), .mem_ready(mem_ready),
    .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src(alu_src), .alu_op(alu_op), .reg_write(reg_write), .illegal(illegal),
    .state(state), .instr_count(instr_count)
  );

  multi_cycle_ctrl #(.CNT_W(2)) dut_w (
    .clk(clk), .rst(rst), .op(op), .zero(zero), .neg(neg), .mem_ready(mem_ready),
    .iord(w_iord), .mem_read(w_mem_read), .mem_write(w_mem_write), .ir_write(w_ir_write),
    .pc_write(w_pc_write), .pc_src(w_pc_src), .reg_dst(w_reg_dst), .mem_to_reg(w_mem_to_reg),
    .alu_src(w_alu_src), .alu_op(w_alu_op), .reg_write(w_reg_write), .illegal(w_illegal),
    .state(w_state), .instr_count(w_instr_count)
  );

  logic [11:0] dut_ctrl, w_ctrl;
  assign dut_ctrl = {iord, mem_read, mem_write, ir_write, pc_write, pc_src,
                     reg_dst, mem_to_reg, alu_src, alu_op, reg_write};
  assign w_ctrl   = {w_iord, w_mem_read, w_mem_write, w_ir_write, w_pc_write, w_pc_src,
                     w_reg_dst, w_mem_to_reg, w_alu_src, w_alu_op, w_reg_write};

  logic [11:0] exp_ctrl;
  logic        exp_ill, chk_ill, check_en, cnt_known;
  logic [31:0] m_count, exp_count;
  logic        cur_z, cur_n;
  bit          idle_rdy = 1'b0;
  int          n_vec = 0;
  int          n_bad = 0;
  int          cyc;

  // Outside memory-handshake phases mem_ready toggles, since it must be ignored there.
  function automatic bit idle();
    idle_rdy = ~idle_rdy;
    return idle_rdy;
  endfunction

  function automatic bit br_taken(logic [5:0] opc, bit z, bit n);
    case (opc)
      6'b000100: return z;
      6'b000101: return !z;
      6'b000111: return !z && !n;
      default:   return 1'b0;
    endcase
  endfunction

  function automatic string op_class(logic [5:0] opc);
    case (opc)
      6'b000000:                                  return "R";
      6'b000100, 6'b000101, 6'b000111:            return "BR";
      6'b100011:                                  return "LW";
      6'b101011:                                  return "SW";
      6'b001000, 6'b001010, 6'b001100, 6'b001101: return "I";
      default:                                    return "BAD";
    endcase
  endfunction

  function automatic logic [11:0] ctrl_of(string ph, logic [5:0] opc, bit z, bit n);
    bit io = 0, mr = 0, mw = 0, irw = 0, pcw = 0, pcs = 0;
    bit rd = 0, m2r = 0, as = 0, rw = 0;
    logic [1:0] ao = 2'b00;
    case (ph)
      "FETCH_WAIT": mr = 1;
      "FETCH_GO":   begin mr = 1; irw = 1; pcw = 1; end
      "EX_R":       ao = 2'b10;
      "EX_I":       begin as = 1; ao = (opc == 6'b001000) ? 2'b00 : 2'b11; end
      "WB_R":       begin rw = 1; rd = 1; end
      "WB_I":       rw = 1;
      "MEM_ADDR":   as = 1;
      "MEM_RD":     begin mr = 1; io = 1; end
      "WB_MEM":     begin rw = 1; m2r = 1; end
      "MEM_WR":     begin mw = 1; io = 1; end
      "BR":         begin pcs = 1; ao = 2'b01; pcw = br_taken(opc, z, n); end
      default:      ;
    endcase
    return {io, mr, mw, irw, pcw, pcs, rd, m2r, as, ao, rw};
  endfunction

  task automatic checkOutput();
    n_vec++;
    if (dut_ctrl !== exp_ctrl) begin
      n_bad++;
      $display("[TB] FAIL ctrl t=%0t got %b want %b", $time, dut_ctrl, exp_ctrl);
    end
    if (w_ctrl !== exp_ctrl) begin
      n_bad++;
      $display("[TB] FAIL ctrl_w t=%0t got %b want %b", $time, w_ctrl, exp_ctrl);
    end
    if (chk_ill && illegal !== exp_ill) begin
      n_bad++;
      $display("[TB] FAIL illegal t=%0t got %b want %b", $time, illegal, exp_ill);
    end
    if (cnt_known && instr_count !== exp_count) begin
      n_bad++;
      $display("[TB] FAIL instr_count t=%0t got %0d want %0d", $time, instr_count, exp_count);
    end
    if (cnt_known && w_instr_count !== exp_count[1:0]) begin
      n_bad++;
      $display("[TB] FAIL instr_count_w t=%0t got %0d want %0d", $time, w_instr_count, exp_count[1:0]);
    end
  endtask

  always @(negedge clk) begin
    #2;
    if (check_en) checkOutput();
  end

  task automatic checkLiteral(string name, logic [31:0] got, logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("[TB] FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  // One clock of stimulus plus the expectations for that cycle; the model's
  // retire count moves on the edge that ends the cycle.
  task automatic step(input logic [11:0] e, input bit ill, input bit ci, input bit rdy,
                      input bit rs, input bit ret, input logic [5:0] opv);
    @(negedge clk);
    #1;
    rst = rs; mem_ready = rdy; op = opv; zero = cur_z; neg = cur_n;
    exp_ctrl = e; exp_ill = ill; chk_ill = ci; exp_count = m_count; check_en = 1'b1;
    @(posedge clk);
    if (rs) begin
      m_count = '0;
      cnt_known = 1'b1;
    end else if (ret) begin
      m_count = m_count + 32'd1;
    end
  endtask

  task automatic doReset(input int n);
    for (int i = 0; i < n; i++) step('0, 1'b0, 1'b0, idle(), 1'b1, 1'b0, 6'b000000);
  endtask

  // Runs one instruction; op is scrambled after DECODE to prove dispatch uses the latched opcode.
  task automatic applyStimulus(input logic [5:0] opc, input bit z, input bit n,
                               input int fw, input int mw, output int cycles);
    string cls;
    logic [5:0] junk;
    cls = op_class(opc);
    junk = ~opc;
    cycles = 0;
    cur_z = z;
    cur_n = n;
    for (int i = 0; i < fw; i++) begin
      step(ctrl_of("FETCH_WAIT", opc, z, n), 0, 1, 0, 0, 0, opc); cycles++;
    end
    step(ctrl_of("FETCH_GO", opc, z, n), 0, 1, 1, 0, 0, opc); cycles++;
    step(ctrl_of("DECODE", opc, z, n), 0, 1, idle(), 0, 0, opc); cycles++;
    case (cls)
      "R": begin
        step(ctrl_of("EX_R", opc, z, n), 0, 1, idle(), 0, 0, junk);
        step(ctrl_of("WB_R", opc, z, n), 0, 1, idle(), 0, 1, junk);
        cycles += 2;
      end
      "I": begin
        step(ctrl_of("EX_I", opc, z, n), 0, 1, idle(), 0, 0, junk);
        step(ctrl_of("WB_I", opc, z, n), 0, 1, idle(), 0, 1, junk);
        cycles += 2;
      end
      "BR": begin
        step(ctrl_of("BR", opc, z, n), 0, 1, idle(), 0, 1, junk);
        cycles += 1;
      end
      "LW": begin
        step(ctrl_of("MEM_ADDR", opc, z, n), 0, 1, idle(), 0, 0, junk); cycles++;
        for (int i = 0; i < mw; i++) begin
          step(ctrl_of("MEM_RD", opc, z, n), 0, 1, 0, 0, 0, junk); cycles++;
        end
        step(ctrl_of("MEM_RD", opc, z, n), 0, 1, 1, 0, 0, junk); cycles++;
        step(ctrl_of("WB_MEM", opc, z, n), 0, 1, idle(), 0, 1, junk); cycles++;
      end
      "SW": begin
        step(ctrl_of("MEM_ADDR", opc, z, n), 0, 1, idle(), 0, 0, junk); cycles++;
        for (int i = 0; i < mw; i++) begin
          step(ctrl_of("MEM_WR", opc, z, n), 0, 1, 0, 0, 0, junk); cycles++;
        end
        step(ctrl_of("MEM_WR", opc, z, n), 0, 1, 1, 0, 1, junk); cycles++;
      end
      default: begin
        for (int i = 0; i < 3; i++) begin
          step('0, 1, 1, idle(), 0, 0, junk); cycles++;
        end
      end
    endcase
  endtask

  logic [5:0] br_op [6] = '{6'b000100, 6'b000101, 6'b000111, 6'b000111, 6'b000101, 6'b000100};
  bit         br_z  [6] = '{1, 1, 0, 0, 0, 0};
  bit         br_n  [6] = '{0, 0, 1, 0, 0, 1};
  logic [5:0] i_op  [4] = '{6'b001100, 6'b001000, 6'b001010, 6'b001101};

  initial begin
    rst = 1'b1; op = '0; zero = 1'b0; neg = 1'b0; mem_ready = 1'b0;
    check_en = 1'b0; cnt_known = 1'b0; m_count = '0; cur_z = 1'b0; cur_n = 1'b0;
    exp_ctrl = '0; exp_ill = 1'b0; chk_ill = 1'b0; exp_count = '0;
    $display("[TB] start");

    doReset(2);
    applyStimulus(6'b000000, 0, 0, 0, 0, cyc);
    checkLiteral("rtype_cycles", cyc, 4);
    #1 checkLiteral("rtype_count", instr_count, 1);

    applyStimulus(6'b100011, 0, 0, 0, 2, cyc);
    checkLiteral("lw_wait2_cycles", cyc, 7);

    for (int i = 0; i < 6; i++) begin
      applyStimulus(br_op[i], br_z[i], br_n[i], 0, 0, cyc);
      checkLiteral("branch_cycles", cyc, 3);
    end

    applyStimulus(6'b101011, 0, 0, 1, 1, cyc);
    checkLiteral("sw_wait_cycles", cyc, 6);

    for (int i = 0; i < 4; i++) begin
      applyStimulus(i_op[i], 0, 0, 0, 0, cyc);
      checkLiteral("itype_cycles", cyc, 4);
    end
    #1 checkLiteral("count_after_mix", instr_count, 13);

    doReset(1);
    for (int i = 0; i < 4; i++) applyStimulus(6'b000100, 1, 0, 0, 0, cyc);
    #1 checkLiteral("wrap_count_w", {30'd0, w_instr_count}, 0);
    checkLiteral("wrap_count_main", instr_count, 4);

    // Reset landing in MEM_RD: outputs dark that cycle, then a fresh fetch with no retire.
    cur_z = 0; cur_n = 0;
    step(ctrl_of("FETCH_GO", 6'b100011, 0, 0), 0, 1, 1, 0, 0, 6'b100011);
    step('0, 0, 1, idle(), 0, 0, 6'b100011);
    step(ctrl_of("MEM_ADDR", 6'b100011, 0, 0), 0, 1, idle(), 0, 0, 6'b100011);
    step(ctrl_of("MEM_RD", 6'b100011, 0, 0), 0, 1, 0, 0, 0, 6'b100011);
    step('0, 0, 0, 1, 1, 0, 6'b100011);
    step(ctrl_of("FETCH_GO", 6'b000000, 0, 0), 0, 1, 1, 0, 0, 6'b000000);
    #1 checkLiteral("abort_count", instr_count, 0);

    doReset(1);
    applyStimulus(6'b000000, 0, 0, 0, 0, cyc);
    applyStimulus(6'b111111, 0, 0, 0, 0, cyc);
    #1 checkLiteral("trap_count", instr_count, 1);
    checkLiteral("trap_illegal", {31'd0, illegal}, 1);
    doReset(1);
    #1 checkLiteral("post_trap_count", instr_count, 0);

    applyStimulus(6'b000010, 0, 0, 0, 0, cyc);
    doReset(1);
    applyStimulus(6'b000000, 0, 0, 0, 0, cyc);
    #1 checkLiteral("final_count", instr_count, 1);

    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    n_bad++;
    $display("[TB] FAIL watchdog got timeout want finish");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/multi_cycle_ctrl.md
Name: multi_cycle_ctrl

Overview:
- Multi-cycle successor to the single-cycle MIPS control decoder.
- Sequences each instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK states and stalls on a shared-memory ready handshake.
- Resolves BEQ/BNE/BGTZ internally from ALU flags, traps illegal opcodes, and counts retired instructions.
- Sits between the instruction register, the shared instruction/data memory, the ALU, and the register bank.

Parameters:
- OP_W, 6, opcode width.
- ALUOP_W, 2, width of alu_op to the ALU control block.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- op  in  OP_W  opcode field from the instruction register.
- zero  in  1  ALU result == 0.
- neg  in  1  ALU result sign bit.
- mem_ready  in  1  memory has completed the current access this cycle.
- iord  out  1  memory address select: 0 = PC, 1 = ALU result.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  load instruction register.
- pc_write  out  1  load PC.
- pc_src  out  1  PC source: 0 = PC+4, 1 = branch target.
- reg_dst  out  1  write-register select: 1 = rd, 0 = rt.
- mem_to_reg  out  1  writeback data select: 1 = memory, 0 = ALU.
- alu_src  out  1  ALU B operand: 1 = immediate, 0 = register.
- alu_op  out  ALUOP_W  operation class for the ALU control block.
- reg_write  out  1  register bank write enable.
- illegal  out  1  sticky illegal-opcode flag.
- state  out  4  current state encoding, for debug.
- instr_count  out  CNT_W  number of retired instructions.

Behaviour:
- Reset: rst sampled at the clk edge.
  - While rst = 1, every control output is 0.
  - On release: state = FETCH, illegal = 0, instr_count = 0.
  - Reset mid-instruction aborts it; nothing is retired.
- Outputs are decoded combinationally from the state register. pc_write in BR is the only output that also depends on flags.
- States and per-state outputs (anything not listed is 0):
  - FETCH: mem_read = 1, iord = 0. Holds while mem_ready = 0. On mem_ready = 1: ir_write = 1, pc_write = 1 (pc_src = 0) for that cycle only, then -> DECODE.
  - DECODE: latches op into op_q, then dispatches:
    - 000000 -> EX_R
    - 000100 / 000101 / 000111 -> BR
    - 100011 / 101011 -> MEM_ADDR
    - 001000 / 001010 / 001100 / 001101 -> EX_I
    - anything else -> TRAP
  - EX_R: alu_op = 10, alu_src = 0. -> WB_R.
  - EX_I: alu_src = 1. alu_op = 00 for ADDI, 11 for SLTI/ANDI/ORI. -> WB_I.
  - WB_R: reg_write = 1, reg_dst = 1. Retire. -> FETCH.
  - WB_I: reg_write = 1, reg_dst = 0. Retire. -> FETCH.
  - MEM_ADDR: alu_op = 00, alu_src = 1. -> MEM_RD (LW) or MEM_WR (SW).
  - MEM_RD: mem_read = 1, iord = 1. Holds until mem_ready = 1, then -> WB_MEM.
  - WB_MEM: reg_write = 1, mem_to_reg = 1, reg_dst = 0. Retire. -> FETCH.
  - MEM_WR: mem_write = 1, iord = 1. Holds until mem_ready = 1. Retire on the mem_ready cycle. -> FETCH.
  - BR: alu_op = 01, alu_src = 0, pc_src = 1. Retire. -> FETCH.
    - pc_write = 1 only when the branch is taken: BEQ if zero; BNE if !zero; BGTZ if !zero && !neg.
  - TRAP: illegal = 1. All other outputs 0. Stays in TRAP until rst.
- Retire: instr_count increments by 1 on the clock edge that leaves the retiring state. It wraps from 2^CNT_W-1 to 0 with no flag.
- Minimum latencies, with mem_ready tied high:
  - branch: 3 cycles
  - R-type, I-type ALU, SW: 4 cycles
  - LW: 5 cycles
  - each wait cycle with mem_ready = 0 adds one cycle.
- mem_ready is ignored outside FETCH, MEM_RD and MEM_WR.
- op changes after DECODE have no effect, because dispatch uses op_q.
- State encoding is 4 bits; unused encodings -> FETCH on the next edge.

Test Plan:
- R-type (op = 000000), mem_ready = 1 -> FETCH, DECODE, EX_R, WB_R. alu_op = 10 in EX_R; reg_write = 1 and reg_dst = 1 in WB_R; instr_count 0 -> 1 after 4 cycles.
- LW (100011) with mem_ready low for 2 cycles in MEM_RD -> mem_read and iord held high through both wait cycles; WB_MEM has mem_to_reg = 1 and reg_write = 1; total 7 cycles.
- BEQ with zero = 1 -> pc_write = 1 and pc_src = 1 in BR. BNE with zero = 1 -> pc_write = 0. BGTZ with zero = 0, neg = 1 -> pc_write = 0. Each retires in 3 cycles.
- SW (101011) -> mem_write = 1 only in MEM_WR and reg_write never 1. ANDI (001100) -> alu_op = 11 and alu_src = 1 in EX_I.
- Illegal op 111111 -> TRAP reached after DECODE, illegal = 1 sticky, instr_count unchanged; rst = 1 for one cycle -> FETCH, illegal = 0, instr_count = 0.
- rst asserted in MEM_RD -> all outputs 0 that cycle, FETCH next, no retire. Preload-free wrap check with CNT_W = 2: 4 retires -> instr_count = 0.
